mips_dmem_ctrl: RTL and testbench
=================================

# mips_dmem_ctrl

Data-memory access controller for the MEM stage of the 5-stage MIPS pipeline. It sequences variable-latency data-memory loads and stores through a req/ack port and stalls the front of the pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding. The MEM/WB register has no enable and captures every cycle, so during stall cycles this block forces bubbles into WB. It also detects misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: ACCESS cycles without ack before fault; legal range 1..2^CNT_W-1.
- CNT_W, 8: timeout counter width.

- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- MemReadMEM  in  1  load in MEM stage (from EX/MEM).
- MemWriteMEM  in  1  store in MEM stage.
- AddrMEM  in  32  byte address (ALU result).
- WriteDataMEM  in  32  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  latched address.
- dmem_wdata  out  32  latched store data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- StallMEM  out  1  freeze upstream stages and PC.
- BubbleWB  out  1  force RegWriteMEM = 0 and MemtoregMEM = 0 into MEM/WB.
- MemReadDataMEM  out  32  load data to MEM/WB.
- MemFault  out  1  sticky fault flag.

## Operation
States: IDLE, ACCESS, DONE, FAULT.

- **IDLE**
  - No access (MemReadMEM = MemWriteMEM = 0): StallMEM = 0, BubbleWB = 0; stay in IDLE.
  - Access with AddrMEM[1:0] = 0: StallMEM = 1, BubbleWB = 1; latch addr, wdata and we (= MemWriteMEM); go to ACCESS; clear counter.
  - Access with AddrMEM[1:0] != 0: StallMEM = 1, BubbleWB = 1; go to FAULT; no request is issued.
  - MemReadMEM and MemWriteMEM both 1: treated as a write.
- **ACCESS**
  - dmem_req = 1; StallMEM = 1; BubbleWB = 1.
  - dmem_ack = 1: latch dmem_rdata if read (writes leave it unchanged); go to DONE.
  - Otherwise the counter increments; when counter = TIMEOUT_CYCLES-1 and no ack, go to FAULT.
  - Ack in the same cycle as the timeout: ack wins.
- **DONE**
  - StallMEM = 0, BubbleWB = 0; MemReadDataMEM holds the latched data while MEM/WB captures.
  - Always go to IDLE. The still-asserted MemReadMEM/MemWriteMEM of the completed instruction is not re-evaluated.
- **FAULT**
  - StallMEM = 0, BubbleWB = 1 (instruction discarded); MemFault set; go to IDLE.
- dmem_ack outside ACCESS is ignored.
- MemReadDataMEM holds its last latched value at all times.
- MemFault clears only on RST.
- dmem_req, StallMEM and BubbleWB are decoded combinationally from state and inputs. dmem_addr, dmem_wdata and dmem_we are registered.

## Timing
- Reset (async, immediate): state = IDLE, counter = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, MemReadDataMEM = 0, MemFault = 0. StallMEM and BubbleWB evaluate per IDLE.
- RST during ACCESS drops dmem_req in the same cycle; a late ack after reset is ignored.
- Access with ack in the first ACCESS cycle: 2 stall cycles (IDLE, ACCESS), then 1 DONE cycle.
- General stall count = 2 + N, where N = ACCESS wait cycles before ack.
- Timeout: FAULT is entered after exactly TIMEOUT_CYCLES ACCESS cycles with no ack.
- Misaligned access: 1 stall cycle, then 1 FAULT cycle.
- Back-to-back memory instructions: IDLE of the second follows DONE of the first, with no dead cycle.

## Structure
- Shared package mips_pkg:
  - state enum {IDLE, ACCESS, DONE, FAULT}
  - WORD_ALIGN_MASK = 2'b11
- Sub-module mips_timeout_ctr: parameterised CNT_W counter with clear, enable and terminal-count output (compare against TIMEOUT_CYCLES-1).

## Test plan
- Reset with memory idle: all outputs at reset values; ALU instruction in MEM gives StallMEM = 0, BubbleWB = 0.
- Load at 0x100, ack 3 cycles after req with rdata 0xDEADBEEF: StallMEM high for 5 cycles; DONE shows MemReadDataMEM = 0xDEADBEEF and BubbleWB = 0.
- Store at 0x200 with data 0x12345678, ack in the first ACCESS cycle: dmem_we = 1, dmem_addr = 0x200, dmem_wdata = 0x12345678; 2 stall cycles; MemReadDataMEM unchanged.
- Load at 0x102: no dmem_req; 1 stall cycle; FAULT cycle with BubbleWB = 1; MemFault stays 1 until RST.
- TIMEOUT_CYCLES = 4 with no ack: dmem_req high for exactly 4 cycles, then FAULT; a subsequent load completes normally.
- RST asserted mid-ACCESS: dmem_req = 0 immediately; an ack after reset release is ignored; state = IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS MEM-stage data-memory controller.
package mips_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mips_timeout_ctr.sv
// ACCESS wait counter; tc flags the last cycle allowed before a timeout fault.
module mips_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/mips_dmem_ctrl.sv
// MEM-stage data-memory sequencer: stalls the front pipeline while a
// load/store is outstanding and bubbles WB, flagging misalign and timeout.
module mips_dmem_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReadMEM,
  input  logic        MemWriteMEM,
  input  logic [31:0] AddrMEM,
  input  logic [31:0] WriteDataMEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallMEM,
  output logic        BubbleWB,
  output logic [31:0] MemReadDataMEM,
  output logic        MemFault
);
  state_t state;
  logic   memAcc;
  logic   misaligned;
  logic   tc;

  assign memAcc     = MemReadMEM | MemWriteMEM;
  assign misaligned = |(AddrMEM[1:0] & WORD_ALIGN_MASK);

  assign dmem_req = (state == ACCESS);
  assign StallMEM = dmem_req | ((state == IDLE) & memAcc);
  assign BubbleWB = StallMEM | (state == FAULT);

  mips_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ctr (
    .CLK(CLK),
    .RST(RST),
    .clr(state == IDLE),
    .en (dmem_req & ~dmem_ack),
    .tc (tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      MemReadDataMEM <= '0;
      MemFault       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memAcc && misaligned) begin
            state    <= FAULT;
            MemFault <= 1'b1;
          end else if (memAcc) begin
            state      <= ACCESS;
            dmem_addr  <= AddrMEM;
            dmem_wdata <= WriteDataMEM;
            dmem_we    <= MemWriteMEM;
          end
        end
        ACCESS: begin
          // ack beats a simultaneous terminal count
          if (dmem_ack) begin
            state <= DONE;
            if (!dmem_we)
              MemReadDataMEM <= dmem_rdata;
          end else if (tc) begin
            state    <= FAULT;
            MemFault <= 1'b1;
          end
        end
        DONE:  state <= IDLE;
        FAULT: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Scoreboard bench for mips_dmem_ctrl with a variable-latency memory model.
module tb_mips_dmem_ctrl;
  logic        CLK;
  logic        RST;
  logic        MemReadMEM;
  logic        MemWriteMEM;
  logic [31:0] AddrMEM;
  logic [31:0] WriteDataMEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallMEM;
  logic        BubbleWB;
  logic [31:0] MemReadDataMEM;
  logic        MemFault;

  mips_dmem_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .MemReadMEM    (MemReadMEM),
    .MemWriteMEM   (MemWriteMEM),
    .AddrMEM       (AddrMEM),
    .WriteDataMEM  (WriteDataMEM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .StallMEM      (StallMEM),
    .BubbleWB      (BubbleWB),
    .MemReadDataMEM(MemReadDataMEM),
    .MemFault      (MemFault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          stalls;
    int          reqs;
    logic        bubble;
    logic [31:0] rdata;
    logic        fault;
    bit          chkBus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   nTotal = 0;
  int   nPass  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nTotal++;
    if (act === exp)
      nPass++;
    else
      $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // memory model: ack in the (lat+1)-th request cycle; lat < 0 never acks
  int          lat     = -1;
  logic [31:0] memData = '0;
  int          reqCyc  = 0;
  bit          lateAck = 0;

  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
  end

  always @(negedge CLK) begin
    dmem_ack = 1'b0;
    if (lateAck) begin
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      lateAck    = 0;
    end else if (dmem_req) begin
      reqCyc++;
      if (lat >= 0 && reqCyc == lat + 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = memData;
      end
    end else begin
      reqCyc = 0;
    end
  end

  // monitor: an operation ends at the first unstalled cycle after stalls
  int stallCnt = 0;
  int reqCnt   = 0;
  int badBub   = 0;

  always @(negedge CLK) begin
    if (RST) begin
      stallCnt = 0;
      reqCnt   = 0;
      badBub   = 0;
    end else if (StallMEM) begin
      stallCnt++;
      if (dmem_req) reqCnt++;
      if (!BubbleWB) badBub++;
    end else if (stallCnt > 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_op", 32'(stallCnt), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("stalls", 32'(stallCnt), 32'(e.stalls));
        chk("reqs", 32'(reqCnt), 32'(e.reqs));
        chk("stall_bubble", 32'(badBub), 0);
        chk("end_bubble", 32'(BubbleWB), 32'(e.bubble));
        chk("rdata", MemReadDataMEM, e.rdata);
        chk("fault", 32'(MemFault), 32'(e.fault));
        chk("req_end", 32'(dmem_req), 0);
        if (e.chkBus) begin
          chk("we", 32'(dmem_we), 32'(e.we));
          chk("addr", dmem_addr, e.addr);
          chk("wdata", dmem_wdata, e.wdata);
        end
      end
      stallCnt = 0;
      reqCnt   = 0;
      badBub   = 0;
    end
  end

  // called at posedge+1; returns at posedge+1 after the op's last cycle
  task automatic doOp(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                      int l, logic [31:0] md, exp_t e);
    bit done;
    MemReadMEM   = rd;
    MemWriteMEM  = wr;
    AddrMEM      = a;
    WriteDataMEM = wd;
    lat          = l;
    memData      = md;
    sb.push_back(e);
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (!StallMEM) done = 1;
    end
    if (!done) chk("op_timeout", 1, 0);
    @(posedge CLK);
    #1;
    MemReadMEM  = 1'b0;
    MemWriteMEM = 1'b0;
  endtask

  function automatic exp_t mk(int s, int r, logic b, logic [31:0] rdat,
                              logic f, bit cb, logic w, logic [31:0] a,
                              logic [31:0] wd);
    exp_t e;
    e.stalls = s;
    e.reqs   = r;
    e.bubble = b;
    e.rdata  = rdat;
    e.fault  = f;
    e.chkBus = cb;
    e.we     = w;
    e.addr   = a;
    e.wdata  = wd;
    return e;
  endfunction

  initial begin
    RST          = 1'b1;
    MemReadMEM   = 1'b0;
    MemWriteMEM  = 1'b0;
    AddrMEM      = '0;
    WriteDataMEM = '0;
    #3;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rdata", MemReadDataMEM, 0);
    chk("rst_fault", 32'(MemFault), 0);
    chk("rst_stall", 32'(StallMEM), 0);
    chk("rst_bubble", 32'(BubbleWB), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("alu_stall", 32'(StallMEM), 0);
    chk("alu_bubble", 32'(BubbleWB), 0);
    @(posedge CLK);
    #1;

    // load, ack on 4th ACCESS cycle (coincides with terminal count)
    doOp(1, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF,
         mk(5, 4, 0, 32'hDEAD_BEEF, 0, 1, 0, 32'h100, 32'h0));
    // store, immediate ack; returned data must not be latched
    doOp(0, 1, 32'h200, 32'h1234_5678, 0, 32'hBAD0_BAD0,
         mk(2, 1, 0, 32'hDEAD_BEEF, 0, 1, 1, 32'h200, 32'h1234_5678));
    // read and write both set: behaves as a write
    doOp(1, 1, 32'h300, 32'hA5A5_5A5A, 1, 32'hBAD1_BAD1,
         mk(3, 2, 0, 32'hDEAD_BEEF, 0, 1, 1, 32'h300, 32'hA5A5_5A5A));
    // back-to-back loads
    doOp(1, 0, 32'h104, 32'h0, 0, 32'h1111_1111,
         mk(2, 1, 0, 32'h1111_1111, 0, 1, 0, 32'h104, 32'h0));
    @(negedge CLK);
    chk("b2b_idle_stall", 32'(StallMEM), 0);
    @(posedge CLK);
    #1;
    doOp(1, 0, 32'h108, 32'h0, 2, 32'h2222_2222,
         mk(4, 3, 0, 32'h2222_2222, 0, 1, 0, 32'h108, 32'h0));
    // misaligned load
    doOp(1, 0, 32'h102, 32'h0, 0, 32'hBAD2_BAD2,
         mk(1, 0, 1, 32'h2222_2222, 1, 1, 0, 32'h108, 32'h0));
    @(negedge CLK);
    chk("fault_sticky", 32'(MemFault), 1);
    chk("alu_after_fault", 32'(BubbleWB), 0);
    @(posedge CLK);
    #1;
    // timeout: 4 request cycles then FAULT
    doOp(1, 0, 32'h400, 32'h0, -1, 32'h0,
         mk(5, 4, 1, 32'h2222_2222, 1, 1, 0, 32'h400, 32'h0));
    // normal load afterwards
    doOp(1, 0, 32'h404, 32'h0, 1, 32'h3333_3333,
         mk(3, 2, 0, 32'h3333_3333, 1, 1, 0, 32'h404, 32'h0));

    // reset in the middle of an access
    MemReadMEM = 1'b1;
    AddrMEM    = 32'h500;
    lat        = -1;
    repeat (3) @(negedge CLK);
    chk("pre_rst_req", 32'(dmem_req), 1);
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    MemReadMEM = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 0);
    chk("mid_rst_fault", 32'(MemFault), 0);
    chk("mid_rst_rdata", MemReadDataMEM, 0);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    lateAck = 1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("late_req", 32'(dmem_req), 0);
    chk("late_stall", 32'(StallMEM), 0);
    chk("late_bubble", 32'(BubbleWB), 0);
    chk("late_rdata", MemReadDataMEM, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
